systolic_tile_sched: RTL and testbench

SYSTOLIC_TILE_SCHED -- requirements
Module: systolic_tile_sched

---
 rtl/systolic_pkg.sv | 19 +
 rtl/sched_wdog.sv | 36 +++
 rtl/systolic_tile_sched.sv | 133 +++++++++++++
 tb/tb_systolic_tile_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and defaults for the systolic tile scheduler
// Purpose: scheduler state encoding plus default tile-count width and watchdog limit.
// Ports: none (package).
package systolic_pkg;

  localparam int TILE_W_DEF   = 8;
  localparam int WDOG_MAX_DEF = 255;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    DRAIN,
    NEXT,
    FAULT
  } sched_state_t;

endpackage

// File: rtl/sched_wdog.sv
// rtl/sched_wdog.sv - per-state cycle watchdog for the tile scheduler
// Purpose: counts cycles while enabled and flags expiry on the WDOG_MAX-th cycle.
// Ports: clk, rst_n (async active-low), clear (restart count), enable (count this
//        cycle), expired (current cycle is the WDOG_MAX-th counted cycle).
module sched_wdog
  import systolic_pkg::*;
#(
  parameter int WDOG_MAX = WDOG_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (WDOG_MAX < 2) ? 1 : $clog2(WDOG_MAX);
  localparam logic [CW-1:0] LIMIT = CW'(WDOG_MAX - 1);

  logic [CW-1:0] count;

  // count holds the number of earlier cycles already spent in the state, so the
  // cycle that sees count == LIMIT is the WDOG_MAX-th one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/systolic_tile_sched.sv
// rtl/systolic_tile_sched.sv - per-tile load/start/run/drain sequencer for a systolic array
// Purpose: accepts a job of cmd_tiles tiles and walks each tile through operand load,
//          PE start, run and result drain, with a watchdog on every wait state.
// Ports: clk, rst_n (async active-low); cmd_valid/cmd_ready/cmd_tiles job request;
//        load_req/load_done operand load; pe_start/load_ready/pe_busy PE control;
//        drain_req/drain_done result drain; tile_idx, busy, done (pulse), err (fault).
module systolic_tile_sched
  import systolic_pkg::*;
#(
  parameter int TILE_W   = TILE_W_DEF,
  parameter int WDOG_MAX = WDOG_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [TILE_W-1:0] cmd_tiles,
  output logic              load_req,
  input  logic              load_done,
  output logic              pe_start,
  output logic              load_ready,
  input  logic              pe_busy,
  output logic              drain_req,
  input  logic              drain_done,
  output logic [TILE_W-1:0] tile_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  sched_state_t      state;
  logic [TILE_W-1:0] tiles_q;
  logic              seen_busy;
  logic              arm;
  logic              leaving;
  logic              wd_en;
  logic              wd_exp;

  // A state is being left on its handshake this cycle; restarts the watchdog so
  // back-to-back counted states (RUN -> DRAIN) each get a full budget.
  always_comb begin
    leaving = 1'b0;
    case (state)
      LOAD:    leaving = load_done;
      RUN:     leaving = seen_busy && !pe_busy;
      DRAIN:   leaving = drain_done;
      default: leaving = 1'b0;
    endcase
  end

  assign wd_en = (state == LOAD) || (state == RUN) || (state == DRAIN);

  sched_wdog #(
    .WDOG_MAX(WDOG_MAX)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (leaving),
    .enable (wd_en),
    .expired(wd_exp)
  );

  // arm goes high on the first edge after reset release; the FSM first acts on
  // the second edge, so a reset released near an edge never races a transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tile_idx  <= '0;
      tiles_q   <= '0;
      seen_busy <= 1'b0;
      done      <= 1'b0;
      arm       <= 1'b0;
    end else begin
      arm  <= 1'b1;
      done <= 1'b0;
      if (arm) begin
        case (state)
          IDLE: begin
            if (cmd_valid) begin
              tiles_q <= cmd_tiles;
              if (cmd_tiles == '0) begin
                done <= 1'b1;
              end else begin
                tile_idx <= '0;
                state    <= LOAD;
              end
            end
          end
          // Handshake completion wins over a watchdog expiring in the same cycle.
          LOAD: begin
            if (load_done)   state <= START;
            else if (wd_exp) state <= FAULT;
          end
          START: begin
            seen_busy <= 1'b0;
            state     <= RUN;
          end
          // pe_busy is registered in the array, so an early low is ignored until
          // busy has been seen high at least once.
          RUN: begin
            if (seen_busy && !pe_busy) state     <= DRAIN;
            else if (wd_exp)           state     <= FAULT;
            else if (pe_busy)          seen_busy <= 1'b1;
          end
          DRAIN: begin
            if (drain_done)  state <= NEXT;
            else if (wd_exp) state <= FAULT;
          end
          NEXT: begin
            if (tile_idx == tiles_q - TILE_W'(1)) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              tile_idx <= tile_idx + TILE_W'(1);
              state    <= LOAD;
            end
          end
          FAULT:   state <= FAULT;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign cmd_ready  = arm && (state == IDLE);
  assign busy       = (state != IDLE);
  assign err        = (state == FAULT);
  assign load_req   = (state == LOAD);
  assign pe_start   = (state == START);
  assign load_ready = (state == START) || (state == RUN);
  assign drain_req  = (state == DRAIN);

endmodule

// File: tb/tb_systolic_tile_sched.sv
// tb/tb_systolic_tile_sched.sv - scoreboard bench for systolic_tile_sched
// Purpose: drives jobs through the scheduler handshakes and checks events and outputs.
// Ports: none (top-level bench).
module tb_systolic_tile_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_tiles = 8'd0;
  logic       load_done = 1'b0;
  logic       pe_busy = 1'b0;
  logic       drain_done = 1'b0;
  logic       cmd_ready, load_req, pe_start, load_ready, drain_req;
  logic [7:0] tile_idx;
  logic       busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_start = 0;
  logic [31:0] sb_q[$];

  systolic_tile_sched #(.TILE_W(8), .WDOG_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tiles(cmd_tiles),
    .load_req(load_req), .load_done(load_done),
    .pe_start(pe_start), .load_ready(load_ready), .pe_busy(pe_busy),
    .drain_req(drain_req), .drain_done(drain_done),
    .tile_idx(tile_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Event monitor: every pe_start / done pulse must match the next scoreboard entry.
  // Encoding: 0x100|tile for a start, 0x200|tile for a done.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n) begin
      if (pe_start) begin
        n_start++;
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'h0;
        check("sb_start", 32'h100 | {24'h0, tile_idx}, e);
      end
      if (done) begin
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'h0;
        check("sb_done", 32'h200 | {24'h0, tile_idx}, e);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return load_req;
      1:       return pe_start;
      2:       return drain_req;
      3:       return done;
      default: return cmd_ready;
    endcase
  endfunction

  task automatic wait_out(input string tag, input int which, input int budget);
    int n = 0;
    while (!sel(which) && n < budget) begin
      tick();
      n++;
    end
    check(tag, sel(which), 1'b1);
  endtask

  task automatic issue(input logic [7:0] n);
    wait_out("wait_cmd_ready", 4, 10);
    cmd_valid = 1'b1;
    cmd_tiles = n;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic push_job(input int n, input bit with_done);
    for (int t = 0; t < n; t++) sb_q.push_back(32'h100 | t);
    if (with_done) sb_q.push_back(32'h200 | (n - 1));
  endtask

  task automatic do_load(input int dly);
    wait_out("wait_load_req", 0, 20);
    repeat (dly) tick();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
  endtask

  task automatic do_run(input int lag, input int len);
    wait_out("wait_pe_start", 1, 5);
    check("start_load_ready", load_ready, 1'b1);
    for (int i = 0; i < lag + len; i++) begin
      pe_busy = (i >= lag);
      tick();
      check("run_hold", {drain_req, load_ready}, 2'b01);
    end
    pe_busy = 1'b0;
    tick();
    check("run_exit_drain", drain_req, 1'b1);
  endtask

  task automatic do_drain(input int dly);
    wait_out("wait_drain_req", 2, 20);
    repeat (dly) tick();
    drain_done = 1'b1;
    tick();
    drain_done = 1'b0;
  endtask

  task automatic finish_job();
    wait_out("wait_done", 3, 5);
    tick();
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", busy, 1'b0);
  endtask

  task automatic run_job(input int n, input int lag, input int len);
    push_job(n, 1'b1);
    issue(8'(n));
    for (int t = 0; t < n; t++) begin
      do_load(2);
      do_run(lag, len);
      do_drain(2);
    end
    finish_job();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check("rst_load_req", load_req, 1'b0);
    check("rst_drain_req", drain_req, 1'b0);
    check("rst_pe_start", pe_start, 1'b0);
    check("rst_load_ready", load_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_tile_idx", tile_idx, 8'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rel_cmd_ready", cmd_ready, 1'b1);
    check("rel_done", done, 1'b0);
  endtask

  initial begin
    int s0;
    // Power-on reset
    repeat (2) tick();
    check("por_busy", busy, 1'b0);
    check("por_err", err, 1'b0);
    check("por_done", done, 1'b0);
    check("por_tile_idx", tile_idx, 8'd0);
    rst_n = 1'b1;
    tick();
    check("por_cmd_ready", cmd_ready, 1'b1);

    // Zero-tile job: done on the next cycle, nothing else
    sb_q.push_back(32'h200);
    issue(8'd0);
    check("zero_done", done, 1'b1);
    check("zero_load_req", load_req, 1'b0);
    check("zero_busy", busy, 1'b0);
    tick();
    check("zero_done_clear", done, 1'b0);
    check("zero_load_req2", load_req, 1'b0);
    check("zero_cmd_ready", cmd_ready, 1'b1);

    // Three-tile job, every handshake after 2 cycles
    s0 = n_start;
    run_job(3, 2, 2);
    check("three_starts", n_start - s0, 3);

    // Late busy: 3 cycles low then 4 high, RUN must hold throughout
    run_job(1, 3, 4);

    // Stray drain_done in LOAD, load_done on the watchdog's last cycle
    push_job(1, 1'b1);
    issue(8'd1);
    drain_done = 1'b1;
    tick();
    drain_done = 1'b0;
    check("stray_load_req", load_req, 1'b1);
    check("stray_drain_req", drain_req, 1'b0);
    repeat (14) tick();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    check("edge_pe_start", pe_start, 1'b1);
    check("edge_err", err, 1'b0);
    do_run(2, 2);
    do_drain(2);
    finish_job();

    // Reset during DRAIN of tile 1 of a 4-tile job
    push_job(2, 1'b0);
    issue(8'd4);
    do_load(2); do_run(2, 2); do_drain(2);
    do_load(2); do_run(2, 2);
    wait_out("wait_drain_t1", 2, 5);
    check("mid_tile_idx", tile_idx, 8'd1);
    reset_pulse();
    run_job(2, 2, 2);

    // Watchdog: load_done never comes, fault after 16 LOAD cycles
    issue(8'd1);
    for (int i = 0; i < 16; i++) begin
      check("wd_load_req", load_req, 1'b1);
      check("wd_err_low", err, 1'b0);
      tick();
    end
    check("wd_err", err, 1'b1);
    check("wd_load_req_off", load_req, 1'b0);
    check("wd_cmd_ready", cmd_ready, 1'b0);
    check("wd_busy", busy, 1'b1);
    cmd_valid = 1'b1;
    load_done = 1'b1;
    repeat (3) tick();
    cmd_valid = 1'b0;
    load_done = 1'b0;
    check("wd_sticky_err", err, 1'b1);
    check("wd_sticky_ready", cmd_ready, 1'b0);
    reset_pulse();
    run_job(1, 2, 2);

    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
